// File: rtl/vdp_cpu_port_if.sv
// VRAM request/acknowledge bus between the VDP CPU port (master) and the
// VRAM / video block (slave). One byte moves per req/ack handshake.
interface vdp_cpu_port_if;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        vram_we;
   logic        vram_req;
   logic [7:0]  vram_rdata;
   logic        vram_ack;

   modport master (
      output vram_addr, vram_wdata, vram_we, vram_req,
      input  vram_rdata, vram_ack
   );

   modport slave (
      input  vram_addr, vram_wdata, vram_we, vram_req,
      output vram_rdata, vram_ack
   );
endinterface

// File: rtl/vdp_cpu_port.sv
// CPU-side port of a TMS9918-style VDP. Decodes Z80 I/O accesses to 0xBE (data)
// and 0xBF (control/status), keeps the 14-bit VRAM pointer, the two-byte control
// latch, R0-R7, the read buffer and the sticky F/C status flags, and moves single
// bytes to/from VRAM over a req/ack handshake with an ack timeout.
// Build option: define VDP_READ_AHEAD_EN for read-ahead (prefetch) behaviour;
// without it, data reads fetch on demand at access start.
module vdp_cpu_port #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           cpu_ce,
   input  logic [7:0]     io_addr,
   input  logic           io_rd_n,
   input  logic           io_wr_n,
   input  logic [7:0]     din,
   output logic [7:0]     dout,
   vdp_cpu_port_if.master vram,
   output logic [63:0]    regs,
   input  logic           vblank_pulse,
   input  logic           coll_pulse,
   input  logic           fifth_valid,
   input  logic [4:0]     fifth_num,
   output logic           int_n,
   output logic           busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_FETCH = 2'd2;

   // Access kinds, latched at access start so the end action does not depend
   // on what the CPU drives on the bus afterwards.
   localparam logic [1:0] K_DWR = 2'd0;
   localparam logic [1:0] K_DRD = 2'd1;
   localparam logic [1:0] K_CWR = 2'd2;
   localparam logic [1:0] K_SRD = 2'd3;

   localparam int            TW         = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic [13:0]   addr;
   logic [7:0]    first_byte;
   logic [7:0]    buffer;
   logic          second;
   logic          flag_f;
   logic          flag_c;
   logic          prev_dec;
   logic [1:0]    kind;

   logic       sel_data, sel_ctrl, dec;
   logic [1:0] cur_kind;
   logic       acc_start, acc_end, idle, ack, timeout, done;
   logic       ctl2, reg_wr, setup, rd_end, clr_flags;
   logic       go_write, go_fetch;
   logic       f_nxt, c_nxt, r1_ie_nxt;

   assign sel_data  = (io_addr == 8'hBE);
   assign sel_ctrl  = (io_addr == 8'hBF);
   assign dec       = (sel_data | sel_ctrl) & (~io_rd_n | ~io_wr_n);
   assign cur_kind  = sel_ctrl ? (~io_wr_n ? K_CWR : K_SRD) : (~io_wr_n ? K_DWR : K_DRD);

   // Each access acts once: on the cpu_ce where decode rises, and on the one where it falls.
   assign acc_start = cpu_ce & dec & ~prev_dec;
   assign acc_end   = cpu_ce & ~dec & prev_dec;

   assign idle      = (state == ST_IDLE);
   assign ack       = vram.vram_ack & ~idle;
   assign timeout   = ~idle & ~vram.vram_ack & (timer == TIMER_LAST);
   assign done      = ack | timeout;

   assign ctl2      = acc_start & (cur_kind == K_CWR) & second;
   assign reg_wr    = ctl2 & din[7];
   assign setup     = ctl2 & ~din[7];
   assign rd_end    = acc_end & (kind == K_DRD);
   assign clr_flags = acc_end & (kind == K_SRD);
   assign go_write  = idle & acc_start & (cur_kind == K_DWR);

`ifdef VDP_READ_AHEAD_EN
   logic read_setup;
   assign read_setup = setup & ~din[6];
   assign go_fetch   = idle & (read_setup | rd_end);
`else
   assign go_fetch   = idle & acc_start & (cur_kind == K_DRD);
`endif

   // A flag pulse arriving in the clearing cycle wins over the clear.
   assign f_nxt     = vblank_pulse | (flag_f & ~clr_flags);
   assign c_nxt     = coll_pulse | (flag_c & ~clr_flags);
   assign r1_ie_nxt = (reg_wr & (din[2:0] == 3'd1)) ? first_byte[5] : regs[13];

   assign vram.vram_addr = addr;
   assign vram.vram_req  = ~idle;
   assign vram.vram_we   = (state == ST_WRITE);
   assign busy           = ~idle;

   // CPU read mux: buffer on the data port, status on the control port, else zero.
   always_comb begin
      dout = 8'h00;
      if (~io_rd_n & sel_data)
         dout = buffer;
      else if (~io_rd_n & sel_ctrl)
         dout = {flag_f, fifth_valid, flag_c, fifth_valid ? fifth_num : 5'h1F};
   end

   // Access edge tracking: decode seen at the previous cpu_ce and the kind of the open access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_dec <= 1'b0;
         kind     <= K_DWR;
      end else if (cpu_ce) begin
         prev_dec <= dec;
         if (acc_start)
            kind <= cur_kind;
      end
   end

   // VRAM handshake FSM with ack timeout; a trigger while busy is simply not taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         timer <= '0;
      end else if (idle) begin
         timer <= '0;
         if (go_write)
            state <= ST_WRITE;
         else if (go_fetch)
            state <= ST_FETCH;
      end else if (done) begin
         state <= ST_IDLE;
      end else begin
         timer <= timer + TW'(1);
      end
   end

   // Control latch (first byte / second flag) and register file writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         second     <= 1'b0;
         first_byte <= 8'h00;
         regs       <= 64'h0;
      end else if (acc_start) begin
         if (cur_kind == K_CWR && !second) begin
            first_byte <= din;
            second     <= 1'b1;
         end else begin
            second <= 1'b0;
         end
         if (reg_wr)
            regs[{din[2:0], 3'b000} +: 8] <= first_byte;
      end
   end

   // VRAM address pointer: loaded by address setup, advanced after writes and reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         addr <= 14'h0000;
      else if (setup)
         addr <= {din[5:0], first_byte};
`ifdef VDP_READ_AHEAD_EN
      else if (rd_end & idle)
         addr <= addr + 14'd1;
`else
      else if (rd_end)
         addr <= addr + 14'd1;
`endif
      else if ((state == ST_WRITE) & done)
         addr <= addr + 14'd1;
   end

`ifdef VDP_READ_AHEAD_EN
   assign vram.vram_wdata = buffer;

   // Read buffer: filled by fetches and, in read-ahead mode, by CPU data writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         buffer <= 8'h00;
      else if ((state == ST_FETCH) & ack)
         buffer <= vram.vram_rdata;
      else if (go_write)
         buffer <= din;
   end
`else
   logic [7:0] wdata;
   assign vram.vram_wdata = wdata;

   // Read buffer from fetches and a separate write-data holding register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buffer <= 8'h00;
         wdata  <= 8'h00;
      end else begin
         if ((state == ST_FETCH) & ack)
            buffer <= vram.vram_rdata;
         if (go_write)
            wdata <= din;
      end
   end
`endif

   // Sticky status flags and the registered frame interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_f <= 1'b0;
         flag_c <= 1'b0;
         int_n  <= 1'b1;
      end else begin
         flag_f <= f_nxt;
         flag_c <= c_nxt;
         int_n  <= ~(f_nxt & r1_ie_nxt);
      end
   end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios followed by randomized CPU traffic,
// all compared against a transaction-level reference model of the port.
module tb_vdp_cpu_port;
`ifdef VDP_READ_AHEAD_EN
   localparam bit RA = 1'b1;
`else
   localparam bit RA = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_ce = 1'b0;
   logic [7:0]  io_addr = 8'h00;
   logic        io_rd_n = 1'b1;
   logic        io_wr_n = 1'b1;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic [63:0] regs;
   logic        vblank_pulse = 1'b0;
   logic        coll_pulse = 1'b0;
   logic        fifth_valid = 1'b0;
   logic [4:0]  fifth_num = 5'h00;
   logic        int_n;
   logic        busy;

   vdp_cpu_port_if vram ();

   vdp_cpu_port #(.ACK_TIMEOUT(15)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_ce       (cpu_ce),
      .io_addr      (io_addr),
      .io_rd_n      (io_rd_n),
      .io_wr_n      (io_wr_n),
      .din          (din),
      .dout         (dout),
      .vram         (vram.master),
      .regs         (regs),
      .vblank_pulse (vblank_pulse),
      .coll_pulse   (coll_pulse),
      .fifth_valid  (fifth_valid),
      .fifth_num    (fifth_num),
      .int_n        (int_n),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // cpu_ce: one clk in seven, changed 2 time units after the edge
   int ce_cnt = 0;
   initial forever begin
      @(posedge clk);
      #2;
      ce_cnt = (ce_cnt + 1) % 7;
      cpu_ce = (ce_cnt == 6);
   end

   // VRAM slave: random ack latency 0..4 cycles once req is seen
   logic [7:0] mem     [16384];
   logic [7:0] exp_mem [16384];
   bit ack_en = 1'b1;
   int dly = -1;
   initial begin
      vram.vram_ack   = 1'b0;
      vram.vram_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (vram.vram_ack) begin
            vram.vram_ack = 1'b0;
         end else if (vram.vram_req && ack_en) begin
            if (dly < 0) dly = int'($urandom_range(0, 4));
            if (dly == 0) begin
               vram.vram_ack = 1'b1;
               if (vram.vram_we) mem[vram.vram_addr] = vram.vram_wdata;
               else              vram.vram_rdata = mem[vram.vram_addr];
               dly = -1;
            end else begin
               dly--;
            end
         end
      end
   end

   int   req_rises = 0;
   logic req_prev = 1'b0;
   always @(posedge clk) begin
      if (vram.vram_req && !req_prev) req_rises <= req_rises + 1;
      req_prev <= vram.vram_req;
   end

   // Reference model state
   logic [13:0] m_addr;
   logic        m_second;
   logic [7:0]  m_first;
   logic [7:0]  m_regs [8];
   logic [7:0]  m_buf;
   logic        m_f, m_c;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [63:0] m_flat();
      logic [63:0] f;
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
      return f;
   endfunction

   function automatic logic m_int();
      return ~(m_f & m_regs[1][5]);
   endfunction

   task automatic model_reset();
      m_addr = 14'h0; m_second = 1'b0; m_first = 8'h00; m_buf = 8'h00;
      m_f = 1'b0; m_c = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
   endtask

   task automatic wait_ce();
      @(posedge clk iff cpu_ce);
      #1;
   endtask

   // One complete CPU I/O access; returns dout sampled while the access is active
   task automatic cpu_access(input logic [7:0] a, input bit is_wr, input logic [7:0] d,
                             input bit pulse_end, output logic [7:0] got);
      io_addr = a;
      din = d;
      if (is_wr) io_wr_n = 1'b0; else io_rd_n = 1'b0;
      wait_ce();
      wait_ce();
      got = dout;
      io_wr_n = 1'b1;
      io_rd_n = 1'b1;
      if (pulse_end) begin
         @(posedge clk iff ce_cnt == 5);
         #1 vblank_pulse = 1'b1;
      end
      wait_ce();
      vblank_pulse = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic ctrl_wr(input logic [7:0] d);
      logic [7:0] g;
      cpu_access(8'hBF, 1'b1, d, 1'b0, g);
      if (!m_second) begin
         m_first = d;
         m_second = 1'b1;
      end else begin
         m_second = 1'b0;
         if (d[7]) m_regs[d[2:0]] = m_first;
         else begin
            m_addr = {d[5:0], m_first};
            if (RA && !d[6]) m_buf = exp_mem[m_addr];
         end
      end
   endtask

   task automatic data_wr(input logic [7:0] d);
      logic [7:0] g;
      cpu_access(8'hBE, 1'b1, d, 1'b0, g);
      m_second = 1'b0;
      exp_mem[m_addr] = d;
      if (RA) m_buf = d;
      m_addr = m_addr + 14'd1;
   endtask

   task automatic data_rd(input string tag);
      logic [7:0] g, want;
      cpu_access(8'hBE, 1'b0, 8'h00, 1'b0, g);
      m_second = 1'b0;
      if (RA) begin
         want = m_buf;
         m_addr = m_addr + 14'd1;
         m_buf = exp_mem[m_addr];
      end else begin
         want = exp_mem[m_addr];
         m_buf = want;
         m_addr = m_addr + 14'd1;
      end
      chk(tag, g, want);
   endtask

   task automatic stat_rd(input string tag, input bit pulse_end);
      logic [7:0] g, want;
      want = {m_f, fifth_valid, m_c, fifth_valid ? fifth_num : 5'h1F};
      cpu_access(8'hBF, 1'b0, 8'h00, pulse_end, g);
      m_second = 1'b0;
      m_f = pulse_end;
      m_c = 1'b0;
      chk(tag, g, want);
   endtask

   task automatic pulse(input bit vb);
      if (vb) vblank_pulse = 1'b1; else coll_pulse = 1'b1;
      @(posedge clk);
      #1;
      vblank_pulse = 1'b0;
      coll_pulse = 1'b0;
      if (vb) m_f = 1'b1; else m_c = 1'b1;
      chk("pulse_int_n", int_n, m_int());
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_addr"}, vram.vram_addr, m_addr);
      chk({tag, "_regs"}, regs, m_flat());
      chk({tag, "_int_n"}, int_n, m_int());
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] ra;
      logic [7:0]  rv;
      int          op;

      for (int i = 0; i < 16384; i++) begin
         mem[i] = 8'($urandom);
         exp_mem[i] = mem[i];
      end
      model_reset();

      // Reset values
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", vram.vram_addr, 14'h0);
      chk("rst_regs", regs, 64'h0);
      chk("rst_int_n", int_n, 1'b1);
      chk("rst_req", vram.vram_req, 1'b0);
      chk("rst_we", vram.vram_we, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_dout", dout, 8'h00);

      // Register write R1 = 0x34, no VRAM traffic
      ctrl_wr(8'h34);
      ctrl_wr(8'h81);
      chk("r1_value", regs[15:8], 8'h34);
      chk("r1_no_req", req_rises, 0);
      check_state("regwr");

      // Write setup to 0x0300 and two data writes
      ctrl_wr(8'h00);
      ctrl_wr(8'h43);
      data_wr(8'hAA);
      data_wr(8'hBB);
      chk("wr_mem300", mem[14'h0300], 8'hAA);
      chk("wr_mem301", mem[14'h0301], 8'hBB);
      chk("wr_addr", vram.vram_addr, 14'h0302);

      // Read setup at 0x1000 and two data reads
      mem[14'h1000] = 8'h11; exp_mem[14'h1000] = 8'h11;
      mem[14'h1001] = 8'h22; exp_mem[14'h1001] = 8'h22;
      ctrl_wr(8'h00);
      ctrl_wr(8'h10);
      data_rd("rd_first");
      data_rd("rd_second");
      chk("rd_addr", vram.vram_addr, 14'h1002);

      // Address wrap at 0x3FFF
      ctrl_wr(8'hFF);
      ctrl_wr(8'h7F);
      data_wr(8'h5A);
      chk("wrap_mem", mem[14'h3FFF], 8'h5A);
      chk("wrap_addr", vram.vram_addr, 14'h0000);

      // Frame interrupt, status read clear, pulse during clear keeps F
      ctrl_wr(8'h20);
      ctrl_wr(8'h81);
      check_state("ie_on");
      pulse(1'b1);
      stat_rd("stat_f_set", 1'b0);
      check_state("stat_cleared");
      pulse(1'b1);
      stat_rd("stat_f_again", 1'b1);
      check_state("stat_kept");
      stat_rd("stat_f_kept", 1'b0);
      check_state("stat_cleared2");

      // Status read resets the control latch
      ctrl_wr(8'h12);
      stat_rd("stat_latch", 1'b0);
      ctrl_wr(8'h00);
      ctrl_wr(8'h40);
      chk("latch_addr", vram.vram_addr, 14'h0000);

      // Missing ack: WRITE times out after 15 cycles and still advances the address
      ack_en = 1'b0;
      io_addr = 8'hBE;
      din = 8'hC3;
      io_wr_n = 1'b0;
      wait_ce();
      repeat (14) @(posedge clk);
      #1 chk("tmo_busy_hold", busy, 1'b1);
      @(posedge clk);
      #1 chk("tmo_busy_drop", busy, 1'b0);
      io_wr_n = 1'b1;
      wait_ce();
      repeat (8) @(posedge clk);
      #1;
      m_second = 1'b0;
      if (RA) m_buf = 8'hC3;
      chk("tmo_mem_kept", mem[m_addr], exp_mem[m_addr]);
      m_addr = m_addr + 14'd1;
      check_state("tmo");
      ack_en = 1'b1;

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         op = int'($urandom_range(0, 5));
         ra = 14'($urandom);
         rv = 8'($urandom);
         case (op)
            0: begin ctrl_wr(rv); ctrl_wr(8'h80 | 8'($urandom_range(0, 7))); end
            1: begin ctrl_wr(ra[7:0]); ctrl_wr({2'b00, ra[13:8]}); end
            2: begin ctrl_wr(ra[7:0]); ctrl_wr({2'b01, ra[13:8]}); end
            3: begin
               data_wr(rv);
               chk("rnd_mem", mem[m_addr - 14'd1], exp_mem[m_addr - 14'd1]);
            end
            4: data_rd("rnd_rd");
            default: begin
               fifth_valid = 1'($urandom);
               fifth_num = 5'($urandom);
               stat_rd("rnd_stat", 1'($urandom));
            end
         endcase
         if ($urandom_range(0, 3) == 0) pulse(1'($urandom));
         check_state("rnd");
      end

      // Reset in the middle of a VRAM write aborts at once
      ack_en = 1'b0;
      io_addr = 8'hBE;
      din = 8'h77;
      io_wr_n = 1'b0;
      wait_ce();
      repeat (2) @(posedge clk);
      #1 chk("rstmid_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("rstmid_busy_off", busy, 1'b0);
      chk("rstmid_req_off", vram.vram_req, 1'b0);
      io_wr_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      ack_en = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_state("rstmid");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vdp_cpu_port.md
# vdp_cpu_port

CPU-side port of the TMS9918-style VDP: decodes Z80 I/O accesses to ports 0xBE (data) and 0xBF (control/status), maintains the 14-bit VRAM address pointer, the two-byte control latch, VDP registers R0–R7, the read-ahead buffer and the sticky status flags. It sits between the tv80n bus decode and the VRAM/video block. It issues single-byte VRAM requests on a req/ack handshake and drives the frame interrupt line back to the CPU.

## Interface
Parameters:
- `ACK_TIMEOUT`, 15: cycles in WRITE/FETCH before a missing `vram_ack` forces return to IDLE.

Ports:
- `clk` in 1: system clock, 25 MHz `cpuClock` domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_ce` in 1: one-cycle pulse per CPU clock (cpuClockEdge).
- `io_addr` in 8: CPU address [7:0].
- `io_rd_n`, `io_wr_n` in 1 each: decoded IORQ&RD, IORQ&WR, active low.
- `din` in 8: CPU data out.
- `dout` out 8: read data for port 0xBE/0xBF.
- `vram_addr` out 14, `vram_wdata` out 8, `vram_we` out 1, `vram_req` out 1.
- `vram_rdata` in 8, `vram_ack` in 1: handshake return.
- `regs` out 64: R7..R0 flattened, R0 in [7:0].
- `vblank_pulse`, `coll_pulse` in 1 each: one-cycle event pulses from video.
- `fifth_valid` in 1, `fifth_num` in 5: too-many-sprites flag and sprite index.
- `int_n` out 1: CPU interrupt, active low.
- `busy` out 1: handshake FSM not IDLE.

## Operation
- Access start: first `cpu_ce` with decode true while previous-`cpu_ce` decode false. Access end: first `cpu_ce` with decode false after a true one. Each access acts exactly once.
- Control write (0xBF), `second` flag 0: `first_byte` <= din, `second` <= 1.
- Control write, `second` 1: `second` <= 0, then by din:
  - din[7]=1: `regs[din[2:0]]` <= `first_byte`.
  - din[7:6]=00: address <= {din[5:0], `first_byte`}; read setup, starts FETCH.
  - din[7:6]=01: address <= {din[5:0], `first_byte`}; write setup, no fetch.
- Data write (0xBE) at start: `second` <= 0; `buffer` <= din; enter WRITE with `vram_addr`=address, `vram_we`=1.
- On ack: address increments mod 2^14 (0x3FFF→0x0000).
- Data read (0xBE): `dout`=`buffer` while active; `second` <= 0 at start; at end, address increments and FETCH starts.
- FETCH: `vram_req`, `vram_we`=0; on ack, `buffer` <= `vram_rdata`.
- Status read (0xBF): `dout`={F, 5S, C, fifth_valid ? fifth_num : 5'h1F}; `second` <= 0 at start. At end, F and C clear.
- Pulse inputs always set F/C; a set in the clearing cycle wins.
- `int_n` = ~(F & R1[5]), registered.
- Other ports: `dout`=0, no action.
- FSM: IDLE → WRITE or FETCH on trigger. Either → IDLE on `vram_ack` or timeout; a timeout in WRITE still increments the address.
- A trigger while not IDLE is dropped, with no address change. CPU spacing (≥7 clk) makes this unreachable when ack ≤6 cycles.

## Timing
- `vram_req` asserts 1 clk after the triggering `cpu_ce`. It holds with stable addr/we/wdata until the ack cycle, then deasserts the next clk.
- Ack is accepted in any cycle while `vram_req`=1, including the first.
- `buffer` and address update on the clk after ack.
- `dout` is combinational from `io_addr`/`io_rd_n`.
- `regs` and `int_n` update 1 clk after their causing event.
- Reset values: address 0, `regs` 0, `second` 0, `first_byte` 0, `buffer` 0, F=C=0, `int_n`=1, `vram_req`=0, `vram_we`=0, `busy`=0, FSM IDLE.
- Reset mid-transaction aborts immediately; a late ack is ignored in IDLE.

## Configuration
- `VDP_READ_AHEAD_EN` defined: read-ahead behaviour as described.
- Undefined: no prefetch.
  - Read setup only loads the address.
  - A data read issues FETCH at access start; `dout` shows `vram_rdata` once acked and `buffer` before that.
  - The address increments at read end.
  - Data writes do not load `buffer`.

## Test plan
- Reset, then control writes 0x34,0x81 → `regs[15:8]`=0x34, `second`=0, no `vram_req`.
- Control 0x00,0x43, data writes 0xAA,0xBB → VRAM 0x0300=0xAA and 0x0301=0xBB, final address 0x0302.
- Preload VRAM 0x1000=0x11, 0x1001=0x22; control 0x00,0x10; two data reads → returns 0x11 then 0x22, address 0x1002 (with `_EN`).
- Address 0x3FFF, data write 0x5A → VRAM 0x3FFF=0x5A, address wraps to 0x0000.
- R1=0x20, `vblank_pulse` → `int_n`=0 after 1 clk; status read returns bit7=1; after read end F=0, `int_n`=1. A pulse in the clear cycle keeps F=1.
- Control write 0x12, then status read, then control 0x00,0x40 → address 0x0000, not 0x0012 (latch reset).
